gate_sequence_detector: RTL and testbench
=========================================

GATE_SEQUENCE_DETECTOR -- requirements
Module: gate_sequence_detector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable synchronized samples required to accept a sensor change; legal range is 1 to 255.
REQ-002 Port clk, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit, is a synchronous active-low reset: reset==0 at a rising clk edge resets the block.
REQ-004 Port outer, input, 1 bit, is the asynchronous outer beam sensor; 1 means blocked.
REQ-005 Port inner, input, 1 bit, is the asynchronous inner beam sensor; 1 means blocked.
REQ-006 Port enter, output, 1 bit, is a one-cycle pulse marking one completed entry; it feeds the occupancy counter's increment.
REQ-007 Port exit, output, 1 bit, is a one-cycle pulse marking one completed exit; it feeds the occupancy counter's decrement.
REQ-008 Port seq_err, output, 1 bit, is a one-cycle pulse marking an illegal sensor transition.

Function
REQ-009 Each sensor SHALL pass through a 2-flop synchronizer; the synchronized value s equals the raw value delayed by 2 clk edges.
REQ-010 Debounce SHALL work per sensor: the debounced value d takes the value of s only after s has differed from d for DEBOUNCE_CYCLES consecutive edges.
REQ-011 In the debounce, the mismatch counter SHALL clear on any edge where s equals d, so glitches shorter than DEBOUNCE_CYCLES are never seen downstream.
REQ-012 The FSM SHALL act on the pair P = {d_outer, d_inner} and has states IDLE, EN_OUT, EN_BOTH, EN_IN, EX_IN, EX_BOTH, EX_OUT and WAIT_CLEAR.
REQ-013 Entry path: IDLE goes to EN_OUT on P=10, EN_OUT to EN_BOTH on P=11, EN_BOTH to EN_IN on P=01, and EN_IN to IDLE on P=00 with enter pulsed.
REQ-014 Exit path: IDLE goes to EX_IN on P=01, EX_IN to EX_BOTH on P=11, EX_BOTH to EX_OUT on P=10, and EX_OUT to IDLE on P=00 with exit pulsed.
REQ-015 Backing out SHALL be silent: a return to the previous P value SHALL step back one state, and P=00 from any non-final state SHALL return to IDLE with no pulse.
REQ-016 Any P transition not listed in REQ-013 to REQ-015 (for example IDLE with P=11, or EN_OUT with P=01) SHALL pulse seq_err for one cycle and enter WAIT_CLEAR.
REQ-017 WAIT_CLEAR SHALL ignore all P values except 00, on which it returns to IDLE with no pulse.
REQ-018 enter, exit and seq_err SHALL be registered, go high in the cycle after the FSM edge that takes the transition, and stay high for exactly 1 cycle.
REQ-019 At most one of enter, exit and seq_err SHALL be high in any cycle.
REQ-020 End-to-end latency from the raw edge that completes a sequence to the output pulse SHALL be 2 + DEBOUNCE_CYCLES + 1 edges.
REQ-021 The block SHALL NOT track lot capacity; saturation at full or empty is the consumer's job.

Reset
REQ-022 On reset: synchronizer flops, debounced values and counters SHALL go to 0, the FSM to IDLE, and enter, exit and seq_err to 0 on the same edge.
REQ-023 Reset mid-sequence SHALL abandon the sequence with no pulse.
REQ-024 If a sensor is still blocked after reset releases, its debounced value SHALL rise after DEBOUNCE_CYCLES edges and the FSM SHALL follow REQ-013 to REQ-016 from IDLE.

Structure
REQ-025 Package gate_pkg SHALL hold the FSM state enum typedef and the default DEBOUNCE_CYCLES constant.
REQ-026 Sub-module sensor_debounce (synchronizer plus debounce counter, one sensor) SHALL be instantiated twice; the FSM and pulse registers live in gate_sequence_detector.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Entry: drive outer/inner as 10, 11, 01, 00 with each step held 10 cycles -> exactly one enter pulse, 7 edges after the final raw 00, and exit=seq_err=0 throughout.
REQ-028 Exit: drive 01, 11, 10, 00 with each step held 10 cycles -> exactly one exit pulse, and no enter.
REQ-029 Back-out: drive 10, 11, 10, 00 -> no pulse on any output, and the FSM ends in IDLE.
REQ-030 Glitch: a 3-cycle outer pulse while idle -> debounced outer stays 0 and no output pulses; a 4-cycle outer pulse -> debounced outer rises, then returns to IDLE silently.
REQ-031 Illegal and reset: drive 00 then 11 directly -> one seq_err pulse, and WAIT_CLEAR holds until 00; separately, assert reset while in EN_BOTH -> no enter, and all outputs are 0 on the reset edge.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared types and constants for the two-beam gate sequence detector.
package gate_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    // Beam pair codes as {outer, inner}; 1 means the beam is blocked.
    localparam logic [1:0] P_CLEAR = 2'b00;
    localparam logic [1:0] P_INNER = 2'b01;
    localparam logic [1:0] P_OUTER = 2'b10;
    localparam logic [1:0] P_BOTH  = 2'b11;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        EN_OUT     = 3'd1,
        EN_BOTH    = 3'd2,
        EN_IN      = 3'd3,
        EX_IN      = 3'd4,
        EX_BOTH    = 3'd5,
        EX_OUT     = 3'd6,
        WAIT_CLEAR = 3'd7
    } gateState_e;

endpackage

// File: rtl/sensor_debounce.sv
// One beam sensor: 2-flop synchronizer followed by a consecutive-mismatch debouncer.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic raw_i,
    output logic deb_o
);

    localparam logic [7:0] LastCount = 8'(DEBOUNCE_CYCLES - 1);

    logic       meta_q;
    logic       sync_q;
    logic       deb_q;
    logic       deb_d;
    logic [7:0] count_q;
    logic [7:0] count_d;

    // Any sample that agrees with the debounced value restarts the run, so short glitches never land.
    always_comb begin
        deb_d   = deb_q;
        count_d = '0;
        if (sync_q != deb_q) begin
            if (count_q == LastCount) begin
                deb_d = sync_q;
            end else begin
                count_d = count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            deb_q   <= 1'b0;
            count_q <= '0;
        end else begin
            meta_q  <= raw_i;
            sync_q  <= meta_q;
            deb_q   <= deb_d;
            count_q <= count_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/gate_sequence_detector.sv
// Two-beam gate: classifies debounced outer/inner beam sequences into entry, exit or error pulses.
module gate_sequence_detector
    import gate_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic outer,
    input  logic inner,
    output logic enter,
    output logic exit,
    output logic seq_err
);

    logic       debOuter;
    logic       debInner;
    logic [1:0] pair;

    gateState_e state_q, state_d;
    logic       enter_q, enter_d;
    logic       exit_q, exit_d;
    logic       err_q, err_d;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uOuter (
        .clk_i    (clk),
        .reset_ni (reset),
        .raw_i    (outer),
        .deb_o    (debOuter)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uInner (
        .clk_i    (clk),
        .reset_ni (reset),
        .raw_i    (inner),
        .deb_o    (debInner)
    );

    assign pair = {debOuter, debInner};

    // Holding the current pair keeps the state; stepping back one pair or clearing is silent.
    always_comb begin
        state_d = state_q;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pair == P_OUTER)      state_d = EN_OUT;
                else if (pair == P_INNER) state_d = EX_IN;
                else if (pair == P_BOTH)  begin state_d = WAIT_CLEAR; err_d = 1'b1; end
            end
            EN_OUT: begin
                if (pair == P_BOTH)       state_d = EN_BOTH;
                else if (pair == P_CLEAR) state_d = IDLE;
                else if (pair == P_INNER) begin state_d = WAIT_CLEAR; err_d = 1'b1; end
            end
            EN_BOTH: begin
                if (pair == P_INNER)      state_d = EN_IN;
                else if (pair == P_OUTER) state_d = EN_OUT;
                else if (pair == P_CLEAR) state_d = IDLE;
            end
            EN_IN: begin
                if (pair == P_CLEAR)      begin state_d = IDLE; enter_d = 1'b1; end
                else if (pair == P_BOTH)  state_d = EN_BOTH;
                else if (pair == P_OUTER) begin state_d = WAIT_CLEAR; err_d = 1'b1; end
            end
            EX_IN: begin
                if (pair == P_BOTH)       state_d = EX_BOTH;
                else if (pair == P_CLEAR) state_d = IDLE;
                else if (pair == P_OUTER) begin state_d = WAIT_CLEAR; err_d = 1'b1; end
            end
            EX_BOTH: begin
                if (pair == P_OUTER)      state_d = EX_OUT;
                else if (pair == P_INNER) state_d = EX_IN;
                else if (pair == P_CLEAR) state_d = IDLE;
            end
            EX_OUT: begin
                if (pair == P_CLEAR)      begin state_d = IDLE; exit_d = 1'b1; end
                else if (pair == P_BOTH)  state_d = EX_BOTH;
                else if (pair == P_INNER) begin state_d = WAIT_CLEAR; err_d = 1'b1; end
            end
            WAIT_CLEAR: begin
                if (pair == P_CLEAR)      state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
            err_q   <= err_d;
        end
    end

    assign enter   = enter_q;
    assign exit    = exit_q;
    assign seq_err = err_q;

endmodule

// File: tb/tb_gate_sequence_detector.sv
// Directed bench for gate_sequence_detector with DEBOUNCE_CYCLES=4.
module tb_gate_sequence_detector;
    import gate_pkg::*;

    localparam int DEB = 4;
    localparam int LATENCY = 2 + DEB + 1;

    logic clk;
    logic reset;
    logic outer;
    logic inner;
    logic enter;
    logic exit;
    logic seq_err;

    int cycle;
    int enterCnt, exitCnt, errCnt, overlapCnt, debOuterHigh;
    int lastEnterCycle, lastExitCycle, lastDriveCycle;
    int errors;
    int checks;

    gate_sequence_detector #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk     (clk),
        .reset   (reset),
        .outer   (outer),
        .inner   (inner),
        .enter   (enter),
        .exit    (exit),
        .seq_err (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle++;

    // Pulse bookkeeping sampled half a period away from the active edge.
    initial begin
        enterCnt = 0; exitCnt = 0; errCnt = 0; overlapCnt = 0; debOuterHigh = 0;
        lastEnterCycle = -1; lastExitCycle = -1;
        forever begin
            @(negedge clk);
            if (enter === 1'b1) begin enterCnt++; lastEnterCycle = cycle; end
            if (exit === 1'b1) begin exitCnt++; lastExitCycle = cycle; end
            if (seq_err === 1'b1) errCnt++;
            if ((int'(enter === 1'b1) + int'(exit === 1'b1) + int'(seq_err === 1'b1)) > 1) overlapCnt++;
            if (dut.debOuter === 1'b1) debOuterHigh++;
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] p, input int hold);
        {outer, inner} = p;
        lastDriveCycle = cycle;
        repeat (hold) @(negedge clk);
    endtask

    int e0, x0, r0, h0;

    task automatic snapshot();
        e0 = enterCnt; x0 = exitCnt; r0 = errCnt; h0 = debOuterHigh;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        outer = 1'b0;
        inner = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_enter", int'(enter), 0);
        checkOutput("reset_exit", int'(exit), 0);
        checkOutput("reset_seq_err", int'(seq_err), 0);
        checkOutput("reset_state", int'(dut.state_q), int'(IDLE));
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Entry sequence
        snapshot();
        applyStimulus(2'b10, 10);
        applyStimulus(2'b11, 10);
        applyStimulus(2'b01, 10);
        applyStimulus(2'b00, 10);
        checkOutput("entry_enter_count", enterCnt - e0, 1);
        checkOutput("entry_latency", lastEnterCycle - lastDriveCycle, LATENCY);
        checkOutput("entry_exit_count", exitCnt - x0, 0);
        checkOutput("entry_err_count", errCnt - r0, 0);
        checkOutput("entry_end_state", int'(dut.state_q), int'(IDLE));

        // Exit sequence
        snapshot();
        applyStimulus(2'b01, 10);
        applyStimulus(2'b11, 10);
        applyStimulus(2'b10, 10);
        applyStimulus(2'b00, 10);
        checkOutput("exit_exit_count", exitCnt - x0, 1);
        checkOutput("exit_latency", lastExitCycle - lastDriveCycle, LATENCY);
        checkOutput("exit_enter_count", enterCnt - e0, 0);
        checkOutput("exit_err_count", errCnt - r0, 0);

        // Back-out
        snapshot();
        applyStimulus(2'b10, 10);
        applyStimulus(2'b11, 10);
        applyStimulus(2'b10, 10);
        checkOutput("backout_mid_state", int'(dut.state_q), int'(EN_OUT));
        applyStimulus(2'b00, 10);
        checkOutput("backout_pulses", (enterCnt - e0) + (exitCnt - x0) + (errCnt - r0), 0);
        checkOutput("backout_end_state", int'(dut.state_q), int'(IDLE));

        // Glitch shorter than the debounce window
        snapshot();
        applyStimulus(2'b10, 3);
        applyStimulus(2'b00, 15);
        checkOutput("glitch3_deb_outer_high", debOuterHigh - h0, 0);
        checkOutput("glitch3_pulses", (enterCnt - e0) + (exitCnt - x0) + (errCnt - r0), 0);

        // Glitch exactly the debounce window long
        snapshot();
        applyStimulus(2'b10, 4);
        applyStimulus(2'b00, 15);
        checkOutput("glitch4_deb_outer_rose", int'((debOuterHigh - h0) > 0), 1);
        checkOutput("glitch4_pulses", (enterCnt - e0) + (exitCnt - x0) + (errCnt - r0), 0);
        checkOutput("glitch4_end_state", int'(dut.state_q), int'(IDLE));

        // Illegal jump straight to both blocked
        snapshot();
        applyStimulus(2'b11, 10);
        checkOutput("illegal_err_count", errCnt - r0, 1);
        checkOutput("illegal_state", int'(dut.state_q), int'(WAIT_CLEAR));
        applyStimulus(2'b10, 10);
        applyStimulus(2'b01, 10);
        checkOutput("wait_clear_hold_state", int'(dut.state_q), int'(WAIT_CLEAR));
        checkOutput("wait_clear_err_count", errCnt - r0, 1);
        applyStimulus(2'b00, 10);
        checkOutput("wait_clear_release", int'(dut.state_q), int'(IDLE));
        checkOutput("illegal_other_pulses", (enterCnt - e0) + (exitCnt - x0), 0);

        // Reset in the middle of an entry
        snapshot();
        applyStimulus(2'b10, 10);
        applyStimulus(2'b11, 10);
        checkOutput("pre_reset_state", int'(dut.state_q), int'(EN_BOTH));
        reset = 1'b0;
        applyStimulus(2'b00, 1);
        checkOutput("reset_edge_enter", int'(enter), 0);
        checkOutput("reset_edge_exit", int'(exit), 0);
        checkOutput("reset_edge_seq_err", int'(seq_err), 0);
        checkOutput("reset_edge_state", int'(dut.state_q), int'(IDLE));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("reset_abandon_pulses", (enterCnt - e0) + (exitCnt - x0) + (errCnt - r0), 0);

        // Sensor still blocked when reset releases
        snapshot();
        reset = 1'b0;
        applyStimulus(2'b10, 3);
        checkOutput("blocked_reset_deb_outer", int'(dut.debOuter), 0);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("blocked_release_deb_outer", int'(dut.debOuter), 1);
        checkOutput("blocked_release_state", int'(dut.state_q), int'(EN_OUT));
        applyStimulus(2'b00, 12);
        checkOutput("blocked_release_end_state", int'(dut.state_q), int'(IDLE));
        checkOutput("blocked_release_pulses", (enterCnt - e0) + (exitCnt - x0) + (errCnt - r0), 0);

        checkOutput("one_hot_outputs", overlapCnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
